sram_arb_ctrl: RTL and testbench



---
 rtl/sram_arb_ctrl.sv | 171 +++++++++++++++++
 tb/tb_sram_arb_ctrl.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_arb_ctrl.sv
// Controller for one asynchronous SRAM bank shared by instruction fetch and the memory stage.
// MEM has fixed priority in IDLE. Every SRAM pin is driven from a register of the IDLE/ADDR/PULSE/HOLD FSM.
module sram_arb_ctrl #(
  parameter int ADDR_W    = 18,
  parameter int DATA_W    = 16,
  parameter int IF_ADDR_W = 16,
  parameter int WAIT_CYC  = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 mem_req,
  input  logic                 mem_rd,
  input  logic                 mem_wr,
  input  logic [ADDR_W-1:0]    mem_addr,
  input  logic [DATA_W-1:0]    mem_wdata,
  output logic                 mem_ack,
  output logic [DATA_W-1:0]    mem_rdata,
  input  logic                 if_req,
  input  logic [IF_ADDR_W-1:0] if_addr,
  output logic                 if_ack,
  output logic [DATA_W-1:0]    if_rdata,
  output logic                 stall_if,
  output logic [ADDR_W-1:0]    sram_addr,
  inout  wire  [DATA_W-1:0]    sram_data,
  output logic                 sram_en_n,
  output logic                 sram_oe_n,
  output logic                 sram_we_n
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ADDR  = 2'd1;
  localparam logic [1:0] S_PULSE = 2'd2;
  localparam logic [1:0] S_HOLD  = 2'd3;

  logic [1:0]        state_q, state_d;
  logic [2:0]        cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              wr_q, wr_d;
  logic              own_if_q, own_if_d;
  logic              en_n_q, en_n_d;
  logic              oe_n_q, oe_n_d;
  logic              we_n_q, we_n_d;
  logic              drv_q, drv_d;
  logic              mem_ack_q, mem_ack_d;
  logic              if_ack_q, if_ack_d;
  logic [DATA_W-1:0] mem_rdata_q, mem_rdata_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    wr_d        = wr_q;
    own_if_d    = own_if_q;
    en_n_d      = en_n_q;
    oe_n_d      = oe_n_q;
    we_n_d      = we_n_q;
    drv_d       = drv_q;
    mem_ack_d   = 1'b0;
    if_ack_d    = 1'b0;
    mem_rdata_d = mem_rdata_q;
    if_rdata_d  = if_rdata_q;

    case (state_q)
      S_IDLE: begin
        // Both selects high counts as a read; neither set leaves the request ignored.
        if (mem_req && (mem_rd || mem_wr)) begin
          addr_d   = mem_addr;
          wdata_d  = mem_wdata;
          wr_d     = ~mem_rd;
          own_if_d = 1'b0;
          en_n_d   = 1'b0;
          drv_d    = ~mem_rd;
          state_d  = S_ADDR;
        end else if (if_req) begin
          addr_d   = ADDR_W'(if_addr);
          wr_d     = 1'b0;
          own_if_d = 1'b1;
          en_n_d   = 1'b0;
          drv_d    = 1'b0;
          state_d  = S_ADDR;
        end
      end

      S_ADDR: begin
        cnt_d   = 3'(WAIT_CYC);
        oe_n_d  = wr_q;
        we_n_d  = ~wr_q;
        state_d = S_PULSE;
      end

      S_PULSE: begin
        if (cnt_q == 3'd0) begin
          oe_n_d  = 1'b1;
          we_n_d  = 1'b1;
          state_d = S_HOLD;
          // The bus is still driven by the SRAM on this edge, so read data is captured here.
          if (!wr_q) begin
            if (own_if_q) if_rdata_d  = sram_data;
            else          mem_rdata_d = sram_data;
          end
          if (own_if_q) if_ack_d  = 1'b1;
          else          mem_ack_d = 1'b1;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end

      S_HOLD: begin
        en_n_d  = 1'b1;
        drv_d   = 1'b0;
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= 3'd0;
      addr_q      <= '0;
      wdata_q     <= '0;
      wr_q        <= 1'b0;
      own_if_q    <= 1'b0;
      en_n_q      <= 1'b1;
      oe_n_q      <= 1'b1;
      we_n_q      <= 1'b1;
      drv_q       <= 1'b0;
      mem_ack_q   <= 1'b0;
      if_ack_q    <= 1'b0;
      mem_rdata_q <= '0;
      if_rdata_q  <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      wr_q        <= wr_d;
      own_if_q    <= own_if_d;
      en_n_q      <= en_n_d;
      oe_n_q      <= oe_n_d;
      we_n_q      <= we_n_d;
      drv_q       <= drv_d;
      mem_ack_q   <= mem_ack_d;
      if_ack_q    <= if_ack_d;
      mem_rdata_q <= mem_rdata_d;
      if_rdata_q  <= if_rdata_d;
    end
  end

  assign sram_addr = addr_q;
  assign sram_en_n = en_n_q;
  assign sram_oe_n = oe_n_q;
  assign sram_we_n = we_n_q;
  assign sram_data = drv_q ? wdata_q : {DATA_W{1'bz}};

  assign mem_ack   = mem_ack_q;
  assign if_ack    = if_ack_q;
  assign mem_rdata = mem_rdata_q;
  assign if_rdata  = if_rdata_q;

  // Fetch is released only in the HOLD cycle of its own access.
  assign stall_if  = if_req && !((state_q == S_HOLD) && own_if_q);

endmodule

// File: tb/tb_sram_arb_ctrl.sv
// Bench for sram_arb_ctrl: a main instance with WAIT_CYC=1 driven by directed and random transactions,
// and two extra instances that show the wait-state extremes of 0 and 7.
module tb_sram_arb_ctrl;
  localparam int AW  = 18;
  localparam int DW  = 16;
  localparam int IAW = 16;
  localparam int W   = 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rst;
  logic           mem_req, mem_rd, mem_wr;
  logic [AW-1:0]  mem_addr;
  logic [DW-1:0]  mem_wdata;
  wire            mem_ack;
  wire  [DW-1:0]  mem_rdata;
  logic           if_req;
  logic [IAW-1:0] if_addr;
  wire            if_ack;
  wire  [DW-1:0]  if_rdata;
  wire            stall_if;
  wire  [AW-1:0]  sram_addr;
  wire  [DW-1:0]  sram_data;
  wire            sram_en_n, sram_oe_n, sram_we_n;

  sram_arb_ctrl #(.ADDR_W(AW), .DATA_W(DW), .IF_ADDR_W(IAW), .WAIT_CYC(W)) dut (
    .clk(clk), .rst(rst),
    .mem_req(mem_req), .mem_rd(mem_rd), .mem_wr(mem_wr),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
    .stall_if(stall_if), .sram_addr(sram_addr), .sram_data(sram_data),
    .sram_en_n(sram_en_n), .sram_oe_n(sram_oe_n), .sram_we_n(sram_we_n)
  );

  // Default memory contents: a fixed pattern, with the fetch test word at 0x00040.
  function automatic logic [DW-1:0] pat(input logic [AW-1:0] a);
    if (a == 18'h00040) return 16'h1234;
    return a[15:0] ^ {a[17:16], 14'h0} ^ 16'h5A5A;
  endfunction

  // Asynchronous SRAM behaviour: drives while enabled with OE low, stores while enabled with WE low.
  logic [DW-1:0] sram_mem [0:(1<<AW)-1];
  bit            written  [0:(1<<AW)-1];
  assign sram_data = (!sram_en_n && !sram_oe_n)
                     ? (written[sram_addr] ? sram_mem[sram_addr] : pat(sram_addr)) : 'z;
  always @(posedge clk) begin
    if (!sram_en_n && !sram_we_n) begin
      sram_mem[sram_addr] <= sram_data;
      written[sram_addr]  <= 1'b1;
    end
  end

  // Wait-state sweep instances: index 0 has WAIT_CYC=0 and index 1 has WAIT_CYC=7. They perform MEM accesses only.
  logic [1:0]    sw_req, sw_wr;
  logic [AW-1:0] sw_a [2];
  wire  [1:0]    sw_ack, sw_iack, sw_stall, sw_en, sw_oe, sw_we;
  wire  [DW-1:0] sw_rd [2];
  wire  [DW-1:0] sw_ird [2];
  wire  [AW-1:0] sw_sa [2];

  for (genvar gi = 0; gi < 2; gi++) begin : g_sw
    wire [DW-1:0] bus;
    assign bus = (!sw_en[gi] && !sw_oe[gi]) ? (sw_sa[gi][15:0] ^ 16'hC3C3) : 'z;
    sram_arb_ctrl #(.ADDR_W(AW), .DATA_W(DW), .IF_ADDR_W(IAW), .WAIT_CYC(gi == 0 ? 0 : 7)) u_sw (
      .clk(clk), .rst(rst),
      .mem_req(sw_req[gi]), .mem_rd(~sw_wr[gi]), .mem_wr(sw_wr[gi]),
      .mem_addr(sw_a[gi]), .mem_wdata(16'hA55A),
      .mem_ack(sw_ack[gi]), .mem_rdata(sw_rd[gi]),
      .if_req(1'b0), .if_addr(16'h0000), .if_ack(sw_iack[gi]), .if_rdata(sw_ird[gi]),
      .stall_if(sw_stall[gi]), .sram_addr(sw_sa[gi]), .sram_data(bus),
      .sram_en_n(sw_en[gi]), .sram_oe_n(sw_oe[gi]), .sram_we_n(sw_we[gi])
    );
  end

  int n_vec = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: words written through the controller, falling back to the default pattern.
  logic [DW-1:0] ref_mem [logic [AW-1:0]];
  logic [DW-1:0] last_mem_rd, last_if_rd;

  function automatic logic [DW-1:0] ref_rd(input logic [AW-1:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : pat(a);
  endfunction

  typedef struct {
    bit            is_if;
    bit            wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    int            start;
  } acc_t;

  // mop: 0 none, 1 read, 2 write, 3 read+write select, 4 neither select
  task automatic drive_mem(input int mop, input logic [AW-1:0] ma, input logic [DW-1:0] mwd);
    mem_req   = (mop != 0);
    mem_rd    = (mop == 1 || mop == 3);
    mem_wr    = (mop == 2 || mop == 3);
    mem_addr  = ma;
    mem_wdata = mwd;
  endtask

  // One transaction group starting from IDLE. Cycle 0 is the first cycle in which the requests are visible.
  // When mem_late is set, MEM arrives one cycle later, while the fetch access is already in flight.
  task automatic run_txn(input int mop, input logic [AW-1:0] ma, input logic [DW-1:0] mwd,
                         input bit ife, input logic [IAW-1:0] ia, input bit mem_late);
    acc_t acc[2];
    int n = 0;
    int last = 3 + W + 3;
    int mem_ack_k = -1;
    int if_ack_k = -1;
    bit mvalid;
    logic exp_en, exp_oe, exp_we;
    int cur;
    logic [DW-1:0] e;
    mvalid = (mop >= 1 && mop <= 3);
    if (mvalid && !mem_late) begin
      acc[n].is_if = 1'b0; acc[n].wr = (mop == 2); acc[n].addr = ma; acc[n].wdata = mwd;
      acc[n].start = n * (4 + W); n++;
    end
    if (ife) begin
      acc[n].is_if = 1'b1; acc[n].wr = 1'b0; acc[n].addr = AW'(ia); acc[n].wdata = '0;
      acc[n].start = n * (4 + W); n++;
    end
    if (mvalid && mem_late) begin
      acc[n].is_if = 1'b0; acc[n].wr = (mop == 2); acc[n].addr = ma; acc[n].wdata = mwd;
      acc[n].start = n * (4 + W); n++;
    end
    for (int i = 0; i < n; i++) begin
      if (acc[i].is_if) if_ack_k = acc[i].start + 3 + W;
      else              mem_ack_k = acc[i].start + 3 + W;
      if (acc[i].start + 4 + W > last) last = acc[i].start + 4 + W;
    end

    @(posedge clk);
    #1;
    if_req  = ife;
    if_addr = ia;
    if (mop != 0 && !mem_late) drive_mem(mop, ma, mwd);

    for (int k = 0; k <= last; k++) begin
      @(negedge clk);
      exp_en = 1'b1; exp_oe = 1'b1; exp_we = 1'b1; cur = -1;
      for (int i = 0; i < n; i++) begin
        if (k >= acc[i].start + 1 && k <= acc[i].start + 3 + W) begin
          exp_en = 1'b0; cur = i;
        end
        if (k >= acc[i].start + 2 && k <= acc[i].start + 2 + W) begin
          if (acc[i].wr) exp_we = 1'b0;
          else           exp_oe = 1'b0;
        end
      end
      check_eq("sram_en_n", 32'(sram_en_n), 32'(exp_en));
      check_eq("sram_oe_n", 32'(sram_oe_n), 32'(exp_oe));
      check_eq("sram_we_n", 32'(sram_we_n), 32'(exp_we));
      check_eq("mem_ack", 32'(mem_ack), 32'(k == mem_ack_k));
      check_eq("if_ack", 32'(if_ack), 32'(k == if_ack_k));
      check_eq("stall_if", 32'(stall_if), 32'(if_req && (k != if_ack_k)));
      if (cur >= 0) begin
        check_eq("sram_addr", 32'(sram_addr), 32'(acc[cur].addr));
        if (acc[cur].wr) check_eq("wr_bus", 32'(sram_data), 32'(acc[cur].wdata));
      end
      for (int i = 0; i < n; i++) begin
        if (k == acc[i].start + 3 + W) begin
          if (acc[i].is_if) begin
            e = ref_rd(acc[i].addr);
            last_if_rd = e;
            check_eq("if_rdata", 32'(if_rdata), 32'(e));
          end else if (acc[i].wr) begin
            ref_mem[acc[i].addr] = acc[i].wdata;
            check_eq("mem_rdata_hold", 32'(mem_rdata), 32'(last_mem_rd));
          end else begin
            e = ref_rd(acc[i].addr);
            last_mem_rd = e;
            check_eq("mem_rdata", 32'(mem_rdata), 32'(e));
          end
        end
      end
      if (mem_ack) mem_req = 1'b0;
      if (if_ack)  if_req  = 1'b0;
      if (mem_late && k == 1) drive_mem(mop, ma, mwd);
      // Inputs of the access already accepted must not matter any more.
      if (n > 0 && k >= 1 && k < acc[0].start + 3 + W) begin
        if (acc[0].is_if) if_addr = IAW'($urandom);
        else begin
          mem_addr  = AW'($urandom);
          mem_wdata = DW'($urandom);
          mem_rd    = 1'($urandom);
          mem_wr    = 1'($urandom);
        end
      end
    end
    mem_req = 1'b0; mem_rd = 1'b0; mem_wr = 1'b0; if_req = 1'b0;
  endtask

  task automatic sweep(input int idx, input int wc, input bit wr, input logic [AW-1:0] a);
    @(posedge clk);
    #1;
    sw_req[idx] = 1'b1;
    sw_wr[idx]  = wr;
    sw_a[idx]   = a;
    for (int k = 0; k <= wc + 4; k++) begin
      @(negedge clk);
      check_eq(wr ? "sw_we_n" : "sw_oe_n", 32'(wr ? sw_we[idx] : sw_oe[idx]),
               32'(!(k >= 2 && k <= 2 + wc)));
      check_eq("sw_idle_strobe", 32'(wr ? sw_oe[idx] : sw_we[idx]), 32'd1);
      check_eq("sw_ack", 32'(sw_ack[idx]), 32'(k == 3 + wc));
      if (!wr && k == 3 + wc) check_eq("sw_rdata", 32'(sw_rd[idx]), 32'(a[15:0] ^ 16'hC3C3));
      if (sw_ack[idx]) sw_req[idx] = 1'b0;
    end
    sw_req[idx] = 1'b0;
  endtask

  initial begin
    int sc, mop;
    logic [AW-1:0] ma;
    logic [DW-1:0] wd;
    logic [IAW-1:0] ia;
    rst = 1'b1;
    mem_req = 1'b0; mem_rd = 1'b0; mem_wr = 1'b0; mem_addr = '0; mem_wdata = '0;
    if_req = 1'b0; if_addr = '0;
    sw_req = '0; sw_wr = '0; sw_a[0] = '0; sw_a[1] = '0;
    last_mem_rd = '0; last_if_rd = '0;
    repeat (3) @(negedge clk);
    check_eq("rst_en_n", 32'(sram_en_n), 32'd1);
    check_eq("rst_oe_n", 32'(sram_oe_n), 32'd1);
    check_eq("rst_we_n", 32'(sram_we_n), 32'd1);
    check_eq("rst_addr", 32'(sram_addr), 32'd0);
    check_eq("rst_mem_ack", 32'(mem_ack), 32'd0);
    check_eq("rst_if_ack", 32'(if_ack), 32'd0);
    check_eq("rst_mem_rdata", 32'(mem_rdata), 32'd0);
    check_eq("rst_if_rdata", 32'(if_rdata), 32'd0);
    check_eq("rst_stall_if", 32'(stall_if), 32'd0);
    rst = 1'b0;

    run_txn(0, '0, '0, 1'b1, 16'h0040, 1'b0);               // fetch of 0x1234
    run_txn(2, 18'h2A5A5, 16'hBEEF, 1'b0, '0, 1'b0);        // MEM write
    run_txn(1, 18'h2A5A5, 16'h0000, 1'b0, '0, 1'b0);        // MEM read back
    run_txn(1, 18'h2A5A5, 16'h0000, 1'b1, 16'h0040, 1'b0);  // simultaneous requests
    run_txn(0, '0, '0, 1'b1, 16'h0041, 1'b0);               // fetch after a MEM read: mem_rdata holds
    run_txn(2, 18'h00041, 16'h7E57, 1'b1, 16'h0041, 1'b1);  // MEM arrives during a fetch
    run_txn(4, 18'h00042, 16'hFFFF, 1'b0, '0, 1'b0);        // neither select: ignored
    run_txn(3, 18'h00041, 16'hFFFF, 1'b0, '0, 1'b0);        // both selects: read

    // Reset during the write strobe.
    @(posedge clk);
    #1;
    drive_mem(2, 18'h3FFFF, 16'hDEAD);
    for (int k = 0; k <= 2; k++) @(negedge clk);
    check_eq("abort_we_low", 32'(sram_we_n), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    check_eq("abort_en_n", 32'(sram_en_n), 32'd1);
    check_eq("abort_oe_n", 32'(sram_oe_n), 32'd1);
    check_eq("abort_we_n", 32'(sram_we_n), 32'd1);
    check_eq("abort_mem_ack", 32'(mem_ack), 32'd0);
    check_eq("abort_mem_rdata", 32'(mem_rdata), 32'd0);
    rst = 1'b0;
    mem_req = 1'b0; mem_wr = 1'b0;
    last_mem_rd = '0; last_if_rd = '0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check_eq("abort_no_ack", 32'(mem_ack), 32'd0);
      check_eq("abort_idle_en", 32'(sram_en_n), 32'd1);
    end
    run_txn(2, 18'h2A500, 16'h0A0A, 1'b0, '0, 1'b0);        // write after the abort
    run_txn(0, '0, '0, 1'b1, 16'h0040, 1'b0);               // if_rdata was cleared by reset

    sweep(0, 0, 1'b0, 18'h01234);
    sweep(0, 0, 1'b1, 18'h01235);
    sweep(1, 7, 1'b0, 18'h2ABCD);
    sweep(1, 7, 1'b1, 18'h2ABCE);

    for (int it = 0; it < 200; it++) begin
      sc  = int'($urandom_range(0, 5));
      mop = int'($urandom_range(1, 3));
      ma  = ($urandom_range(0, 1) != 0 ? 18'h2A500 : 18'h00000) | AW'($urandom_range(0, 63));
      ia  = IAW'($urandom_range(0, 63));
      wd  = DW'($urandom);
      case (sc)
        0:       run_txn(mop, ma, wd, 1'b0, ia, 1'b0);
        1:       run_txn(0,   ma, wd, 1'b1, ia, 1'b0);
        2:       run_txn(mop, ma, wd, 1'b1, ia, 1'b0);
        3:       run_txn(mop, ma, wd, 1'b1, ia, 1'b1);
        4:       run_txn(4,   ma, wd, 1'b0, ia, 1'b0);
        default: run_txn(4,   ma, wd, 1'b1, ia, 1'b0);
      endcase
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
